uart_rx: RTL and testbench

UART receiver: the receive-side counterpart of the UART_TX serializer and its parity calculator. It oversamples the serial line `RX_IN` with a programmable prescale and detects the start bit. It deserializes `DATA_WIDTH` data bits LSB first, checks optional even/odd parity using the same convention as the transmitter, checks the stop bit, and presents the parallel word with a one-cycle valid strobe.

---
 rtl/uart_rx.sv | 178 +++++++++++++++++
 tb/tb_uart_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: oversamples RX_IN, majority-votes three mid-bit samples,
// deserializes LSB first, checks optional even/odd parity and the stop bit,
// and emits registered one-cycle strobes for valid data or framing errors.
module uart_rx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0]          LAST_BIT = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]          ONE_B    = BIT_W'(1);
    localparam logic [PRESCALE_WIDTH-1:0] ONE_P    = PRESCALE_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                      state, next_state;
    logic [PRESCALE_WIDTH-1:0]   edge_cnt;
    logic [BIT_W-1:0]            bit_cnt;
    logic [DATA_WIDTH-1:0]       shift_reg;
    logic                        par_en_q;
    logic                        par_typ_q;
    logic                        samp_a;     // sample at edge P/2-1
    logic                        samp_b;     // sample at edge P/2
    logic                        bit_val;    // registered majority of current bit
    logic                        par_flag;   // parity mismatch seen in this frame

    // Sampling-point decodes; Prescale is only legal as 8/16/32 so all three
    // sample edges sit strictly between 0 and P-1.
    logic [PRESCALE_WIDTH-1:0]   half;
    logic [PRESCALE_WIDTH-1:0]   last_edge;
    logic                        at_s0, at_s1, at_s2, at_last;
    logic                        maj;
    logic                        exp_par;
    logic                        dv_next, pe_next, se_next;

    assign half      = Prescale >> 1;
    assign last_edge = Prescale - ONE_P;
    assign at_s0     = (edge_cnt == half - ONE_P);
    assign at_s1     = (edge_cnt == half);
    assign at_s2     = (edge_cnt == half + ONE_P);
    assign at_last   = (edge_cnt == last_edge);

    // Third sample is taken live from RX_IN at edge P/2+1.
    assign maj = (samp_a & samp_b) | (samp_a & RX_IN) | (samp_b & RX_IN);

    // Even parity is XOR of the data; odd parity is its complement.
    assign exp_par = (^shift_reg) ^ par_typ_q;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and strobe decode.
    always_comb begin
        next_state = state;
        dv_next    = 1'b0;
        pe_next    = 1'b0;
        se_next    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!RX_IN) next_state = START;
            end
            START: begin
                // A start bit that votes high was a glitch: abandon the frame.
                if (at_s2 && maj)  next_state = IDLE;
                else if (at_last)  next_state = DATA;
            end
            DATA: begin
                if (at_last && bit_cnt == LAST_BIT)
                    next_state = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (at_last) begin
                    next_state = STOP;
                    pe_next    = par_flag;
                end
            end
            STOP: begin
                if (at_last) begin
                    next_state = IDLE;
                    se_next    = ~bit_val;
                    dv_next    = bit_val & ~par_flag;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Edge counter: the cycle that first sees RX_IN low is edge 0, so the
    // first START cycle is edge 1; wraps at P-1 and clears on return to IDLE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                     edge_cnt <= '0;
        else if (next_state == IDLE) edge_cnt <= '0;
        else if (state == IDLE)      edge_cnt <= ONE_P;
        else if (at_last)            edge_cnt <= '0;
        else                         edge_cnt <= edge_cnt + ONE_P;
    end

    // Mid-bit samples and the registered majority decision.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            samp_a  <= 1'b0;
            samp_b  <= 1'b0;
            bit_val <= 1'b0;
        end else if (state != IDLE) begin
            if (at_s0) samp_a  <= RX_IN;
            if (at_s1) samp_b  <= RX_IN;
            if (at_s2) bit_val <= maj;
        end
    end

    // Frame options are captured at the start edge and held for the frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else if (state == IDLE && !RX_IN) begin
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
        end
    end

    // Data shift register, LSB arrives first so shift in from the top.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                       shift_reg <= '0;
        else if (state == DATA && at_s2) shift_reg <= {maj, shift_reg[DATA_WIDTH-1:1]};
    end

    // Data bit counter, advanced at the end of each data bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                       bit_cnt <= '0;
        else if (next_state == IDLE)   bit_cnt <= '0;
        else if (state == DATA && at_last)
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + ONE_B;
    end

    // Parity error flag: cleared at frame start, set on a voted mismatch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                           par_flag <= 1'b0;
        else if (state == IDLE && !RX_IN)  par_flag <= 1'b0;
        else if (state == PARITY && at_s2) par_flag <= (maj != exp_par);
    end

    // Registered output strobes; P_DATA only loads on a clean frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            P_DATA     <= '0;
        end else begin
            data_valid <= dv_next;
            par_err    <= pe_next;
            stp_err    <= se_next;
            if (dv_next) P_DATA <= shift_reg;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames from the test plan plus randomized
// frames, each checked against a frame-level model of expected strobes.
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] d;
    } ev_t;

    ev_t        log_q[$];
    ev_t        exp_q[$];
    logic [7:0] exp_pdata = 8'h00;
    int         n_assert  = 0;
    int         n_fail    = 0;

    // Record every strobe cycle seen on the outputs.
    always @(negedge CLK)
        if (data_valid || par_err || stp_err)
            log_q.push_back('{cyc, data_valid, par_err, stp_err, P_DATA});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one frame; cycle 0 is the first low cycle. Expected strobes are
    // derived from the frame contents. abort_at >= 0 stops after that many
    // cycles and records no expectation.
    task automatic send_frame(input logic [7:0] data, input int p, input logic pen,
                              input logic ptyp, input logic flip_par, input logic stop_b,
                              input int glitch_k, input int abort_at);
        logic bits[$];
        logic par_sent;
        int   f, t0, k, e;
        par_sent = ((^data) ^ ptyp) ^ flip_par;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (pen) bits.push_back(par_sent);
        bits.push_back(stop_b);
        f        = bits.size();
        Prescale = p[5:0];
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        t0       = cyc;
        for (int n = 0; n < f * p; n++) begin
            if (abort_at >= 0 && n == abort_at) begin
                RX_IN = 1'b1;
                return;
            end
            k     = n / p;
            e     = n % p;
            RX_IN = bits[k] ^ ((k == glitch_k) && (e == p / 2));
            @(posedge CLK); #1;
            // Options must be ignored after the start edge.
            if (n == 0) begin
                PAR_EN  = 1'($urandom);
                PAR_TYP = 1'($urandom);
            end
        end
        RX_IN = 1'b1;
        if (pen && flip_par)
            exp_q.push_back('{t0 + (f - 1) * p, 1'b0, 1'b1, 1'b0, 8'h00});
        if (!stop_b) begin
            exp_q.push_back('{t0 + f * p, 1'b0, 1'b0, 1'b1, 8'h00});
        end else if (!(pen && flip_par)) begin
            exp_q.push_back('{t0 + f * p, 1'b1, 1'b0, 1'b0, data});
            exp_pdata = data;
        end
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    // Compare recorded strobes to the expected list, then P_DATA hold value.
    task automatic check_events(input string tag);
        ev_t e, g;
        idle(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (log_q.size() == 0) begin
                chk({tag, "_event_present"}, log_q.size(), exp_q.size() + 1);
            end else begin
                g = log_q.pop_front();
                chk({tag, "_cycle"}, g.c, e.c);
                chk({tag, "_data_valid"}, g.dv, e.dv);
                chk({tag, "_par_err"}, g.pe, e.pe);
                chk({tag, "_stp_err"}, g.se, e.se);
                if (e.dv) chk({tag, "_p_data"}, g.d, e.d);
            end
        end
        chk({tag, "_extra_strobes"}, log_q.size(), 0);
        log_q.delete();
        chk({tag, "_p_data_hold"}, P_DATA, exp_pdata);
    endtask

    initial begin
        int p, gap, gk;
        RST      = 1'b1;
        RX_IN    = 1'b1;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        Prescale = 6'd8;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_p_data", P_DATA, 0);
        chk("reset_data_valid", data_valid, 0);
        chk("reset_par_err", par_err, 0);
        chk("reset_stp_err", stp_err, 0);
        RST = 1'b0;
        idle(2);

        // P=8 even parity, clean 0xA5 then same frame with wrong parity bit.
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1);
        check_events("p8_good");
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1);
        check_events("p8_parerr");

        // P=16 no parity, stop bit low, then a clean frame.
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        check_events("p16_stperr");
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        check_events("p16_good");

        // P=32 back-to-back frames with a glitch at mid data bit 3.
        send_frame(8'h3C, 32, 1'b0, 1'b0, 1'b0, 1'b1, 4, -1);
        send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b0, 1'b1, 4, -1);
        check_events("p32_b2b");

        // False start: 3 low cycles; a frame starting in cycle 10 must decode.
        Prescale = 6'd16;
        RX_IN    = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        RX_IN = 1'b1;
        repeat (7) begin @(posedge CLK); #1; end
        send_frame(8'h96, 16, 1'b1, 1'b1, 1'b0, 1'b1, -1, -1);
        check_events("false_start");

        // Reset in cycle 40 of a frame, then a clean odd-parity 0x81.
        send_frame(8'h5A, 8, 1'b1, 1'b1, 1'b0, 1'b1, -1, 40);
        RST = 1'b1;
        #1;
        chk("midreset_p_data", P_DATA, 0);
        chk("midreset_data_valid", data_valid, 0);
        chk("midreset_par_err", par_err, 0);
        chk("midreset_stp_err", stp_err, 0);
        exp_pdata = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        idle(2);
        check_events("after_reset");
        send_frame(8'h81, 8, 1'b1, 1'b1, 1'b0, 1'b1, -1, -1);
        check_events("odd_0x81");

        // Randomized frames with random gaps (0 = back-to-back).
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 2))
                0:       p = 8;
                1:       p = 16;
                default: p = 32;
            endcase
            gk  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1;
            gap = $urandom_range(0, 2);
            send_frame(8'($urandom), p, 1'($urandom), 1'($urandom),
                       $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, gk, -1);
            if (gap > 0) idle(gap);
        end
        check_events("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
